// File: rtl/seq_pkg.sv
// Shared definitions for the LED pattern sequencer: state encoding,
// parameter defaults and the pattern table.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int NSTEPS_DEF = 8;
    localparam int LEDW_DEF   = 8;

    // Walking one; entries 0..7 form the default 8-step, 8-bit pattern.
    // The table supports up to 16 steps and LED words up to 16 bits.
    localparam logic [15:0] PATTERN [16] = '{
        16'h0001, 16'h0002, 16'h0004, 16'h0008,
        16'h0010, 16'h0020, 16'h0040, 16'h0080,
        16'h0100, 16'h0200, 16'h0400, 16'h0800,
        16'h1000, 16'h2000, 16'h4000, 16'h8000
    };

endpackage

// File: rtl/pattern_rom.sv
// Combinational lookup of the LED word for a given step index.
module pattern_rom
    import seq_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEF,
    parameter int LEDW   = LEDW_DEF
) (
    input  logic [$clog2(NSTEPS)-1:0] step,
    output logic [LEDW-1:0]           word
);

    logic [3:0] idx_s;

    // Table lookup, index zero-extended to the table depth
    always_comb begin
        idx_s = 4'(step);
        word  = PATTERN[idx_s][LEDW-1:0];
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Steps an LED pattern on upstream timer ticks, with start/pause/abort
// control, optional looping and a timer-clear pulse on every entry to RUN.
module pattern_sequencer
    import seq_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEF,
    parameter int LEDW   = LEDW_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop,
    output logic [LEDW-1:0]           leds,
    output logic [$clog2(NSTEPS)-1:0] step,
    output logic                      busy,
    output logic                      done,
    output logic                      timer_clr
);

    localparam int SW = $clog2(NSTEPS);
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    seq_state_e     state_r;
    seq_state_e     state_nxt_s;
    logic [SW-1:0]  step_r;
    logic [SW-1:0]  step_nxt_s;
    logic [LEDW-1:0] leds_r;
    logic [LEDW-1:0] leds_nxt_s;
    logic [LEDW-1:0] rom_word_s;
    logic           timer_clr_r;
    logic           clr_nxt_s;

    // LED word for the step about to be registered, so leds track step with no lag
    pattern_rom #(
        .NSTEPS (NSTEPS),
        .LEDW   (LEDW)
    ) u_rom (
        .step (step_nxt_s),
        .word (rom_word_s)
    );

    // Next-state, next-step and timer-clear decode; stop always dominates start
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        clr_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop) begin
                    step_nxt_s = '0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    step_nxt_s  = '0;
                    clr_nxt_s   = 1'b1;
                end else begin
                    step_nxt_s = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_PAUSE;
                end else if (tick) begin
                    if (step_r != LAST_STEP) begin
                        step_nxt_s = step_r + SW'(1);
                    end else if (loop) begin
                        step_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    step_nxt_s  = '0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    clr_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                    step_nxt_s  = '0;
                end else if (start) begin
                    state_nxt_s = ST_RUN;
                    step_nxt_s  = '0;
                    clr_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                step_nxt_s  = '0;
            end
        endcase
    end

    // LEDs are dark in IDLE, otherwise show the pattern word for the step
    always_comb begin
        if (state_nxt_s == ST_IDLE) begin
            leds_nxt_s = '0;
        end else begin
            leds_nxt_s = rom_word_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            step_r      <= '0;
            leds_r      <= '0;
            timer_clr_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            step_r      <= step_nxt_s;
            leds_r      <= leds_nxt_s;
            timer_clr_r <= clr_nxt_s;
        end
    end

    assign leds      = leds_r;
    assign step      = step_r;
    assign timer_clr = timer_clr_r;
    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with hand-computed expectations.
module tb_pattern_sequencer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] leds;
    logic [2:0] step;
    logic       busy;
    logic       done;
    logic       timer_clr;

    int checks;
    int errors;
    int clr_count;

    logic [7:0] exp_leds [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};

    pattern_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .leds      (leds),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .timer_clr (timer_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_leds, input logic [2:0] e_step,
                           input logic e_busy, input logic e_done, input logic e_clr);
        chk({tag, ".leds"}, 16'(leds), 16'(e_leds));
        chk({tag, ".step"}, 16'(step), 16'(e_step));
        chk({tag, ".busy"}, 16'(busy), 16'(e_busy));
        chk({tag, ".done"}, 16'(done), 16'(e_done));
        chk({tag, ".clr"},  16'(timer_clr), 16'(e_clr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_count = 0;
        reset = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;

        // reset state, then remain idle with no start
        #12;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        cyc();
        chk_all("idle_hold", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // one-shot run, loop=0
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("start", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
        cyc();
        chk_all("run0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (i < 8) begin
                chk_all("walk", exp_leds[i], 3'(i), 1'b1, 1'b0, 1'b0);
            end else begin
                chk_all("done", 8'h80, 3'd7, 1'b0, 1'b1, 1'b0);
            end
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk_all("done_tick_ignored", 8'h80, 3'd7, 1'b0, 1'b1, 1'b0);

        // restart from DONE with looping
        loop  = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("restart", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 11; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk_all("loop", exp_leds[i % 8], 3'(i % 8), 1'b1, 1'b0, 1'b0);
        end

        // stop with coincident tick at step 3 pauses and discards the tick
        stop = 1'b1;
        tick = 1'b1;
        cyc();
        stop = 1'b0;
        chk_all("pause", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
        cyc();
        tick = 1'b0;
        chk_all("pause_tick_ignored", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("resume", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
        cyc();
        chk_all("resume_hold", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);

        // abort from PAUSE, then start+stop in IDLE
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        chk_all("pause2", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
        stop = 1'b1;
        cyc();
        chk_all("abort", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk_all("both_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // start held 20 cycles with ticks: single timer_clr pulse
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick = ((k % 4) == 3);
            cyc();
            if (timer_clr) clr_count++;
        end
        tick  = 1'b0;
        start = 1'b0;
        chk("held_start.clr_count", 16'(clr_count), 16'd1);
        chk_all("held_start", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0);

        // asynchronous reset between edges at step 5
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        cyc();
        cyc();
        chk_all("post_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("post_reset_start", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NSTEPS, default 8, number of pattern steps (power of two, 2..16).
REQ-002 Parameter LEDW, default 8, LED output width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-cycle interval pulse from the upstream timer (its terminal-count output).
REQ-006 start  input  1  level sampled each cycle; start or resume the sequence.
REQ-007 stop  input  1  level sampled each cycle; pause, or abort when already paused.
REQ-008 loop  input  1  1 = wrap after the last step; 0 = finish at the last step.
REQ-009 leds  output  LEDW  current pattern word.
REQ-010 step  output  clog2(NSTEPS)  current step index.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  high in DONE.
REQ-013 timer_clr  output  1  one-cycle pulse that clears the upstream timer so the first interval is full length.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, all registered.
REQ-015 IDLE: start=1, stop=0 -> RUN with step=0 and timer_clr=1 for exactly one cycle.
REQ-016 RUN: tick=1, stop=0, step<NSTEPS-1 -> step+1.
REQ-017 RUN: tick=1, stop=0, step=NSTEPS-1, loop=1 -> step=0, stay in RUN.
REQ-018 RUN: tick=1, stop=0, step=NSTEPS-1, loop=0 -> DONE, step held at NSTEPS-1.
REQ-019 RUN: stop=1 -> PAUSE, step held; a coincident tick SHALL be discarded.
REQ-020 PAUSE: start=1, stop=0 -> RUN, step unchanged, one-cycle timer_clr pulse.
REQ-021 PAUSE: stop=1 -> IDLE, step=0.
REQ-022 DONE: start=1, stop=0 -> RUN, step=0, one-cycle timer_clr pulse.
REQ-023 DONE: stop=1 -> IDLE, step=0.
REQ-024 start and stop both high SHALL be treated as stop alone in every state.
REQ-025 tick SHALL be ignored in IDLE, PAUSE and DONE.
REQ-026 Holding start high SHALL NOT retrigger timer_clr while in RUN; a pulse fires only on the state transition.
REQ-027 leds SHALL equal PATTERN[step] in RUN, PAUSE and DONE, and SHALL be 0 in IDLE.
REQ-028 leds SHALL be registered and change on the same edge as step, i.e. zero extra latency relative to step.
REQ-029 busy and done SHALL be decoded from the state register, with no combinational path from any input.
REQ-030 step arithmetic SHALL be unsigned and modulo NSTEPS; no other wrap path exists.

Reset
REQ-031 Asserting reset (low) SHALL immediately force IDLE, step=0, leds=0, busy=0, done=0 and timer_clr=0, including mid-sequence.
REQ-032 After reset deasserts, the block SHALL stay in IDLE until start is sampled high.

Structure
REQ-033 A shared package seq_pkg SHALL hold the state enumeration, NSTEPS/LEDW defaults and the PATTERN constant table.
REQ-034 Default PATTERN SHALL be 01,02,04,08,10,20,40,80 hex, a walking one.
REQ-035 The pattern lookup SHALL live in a sub-module pattern_rom (step in, LEDW word out, purely combinational); FSM and registers stay in the top.

Verification
REQ-036 Reset low, then start for 1 cycle, then 8 ticks with loop=0 -> timer_clr one pulse; leds 01,02,...,80; DONE after the 8th tick; done=1; leds=80.
REQ-037 loop=1, 9 ticks from step 0 -> step returns to 0 after the 8th tick and step=1 (leds=02) after the 9th; busy stays 1.
REQ-038 At step 3, assert stop coincident with tick -> PAUSE, step=3, leds=08; then start -> RUN, step=3, timer_clr pulse.
REQ-039 In PAUSE, stop -> IDLE, step=0, leds=00; start and stop together in IDLE -> remains IDLE, no timer_clr.
REQ-040 Pull reset low asynchronously between clock edges at step 5 -> all outputs 0 before the next edge; IDLE after release.
REQ-041 start held high for 20 cycles with ticks present -> exactly one timer_clr pulse; ticks advance step normally.
